// File: rtl/axis_frame_arbiter_if.sv
// AXI-Stream bundle used on both sides of the frame arbiter.
// N lanes share one interface; lane i occupies bit i and tdata slice i.
interface axis_frame_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int N      = 1
);
  logic [N-1:0]        tvalid;
  logic [N*DATA_W-1:0] tdata;
  logic [N-1:0]        tlast;
  logic [N-1:0]        tuser;
  logic [N-1:0]        tready;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-atomic round-robin arbiter: locks one source from its tuser beat until the
// tlast that ends its final line, flushes stray non-SOF beats while idle.
module axis_frame_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_SRC            = 2,
  parameter int IDX_W              = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [15:0]          cfg_lines,
  input  logic                 err_clr,
  axis_frame_arbiter_if.slave  s_axis,
  axis_frame_arbiter_if.master m_axis,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 frame_done,
  output logic [15:0]          drop_cnt,
  output logic                 sof_err
);
  localparam int W = C_AXIS_TDATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [15:0]      lines_tgt_q, lines_tgt_d;
  logic [15:0]      line_cnt_q, line_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             first_q, first_d;
  logic             frame_done_q, frame_done_d;
  logic             sof_err_q, sof_err_d;

  logic [NUM_SRC-1:0] cand, stray;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [4:0]         stray_n;
  logic [16:0]        drop_sum;
  logic               sel_valid, sel_last, sel_user;
  logic [W-1:0]       sel_data;
  logic               beat, premature;
  logic [15:0]        cnt_eff;

  assign cand  = s_axis.tvalid & s_axis.tuser;
  assign stray = s_axis.tvalid & ~s_axis.tuser;

  // first SOF candidate at or after rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!pick_found && cand[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    stray_n = '0;
    for (int k = 0; k < NUM_SRC; k++) stray_n = stray_n + 5'(stray[k]);
  end

  assign sel_valid = s_axis.tvalid[grant_idx_q];
  assign sel_last  = s_axis.tlast[grant_idx_q];
  assign sel_user  = s_axis.tuser[grant_idx_q];
  assign sel_data  = s_axis.tdata[grant_idx_q*W +: W];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    lines_tgt_d   = lines_tgt_q;
    line_cnt_d    = line_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    first_d       = first_q;
    frame_done_d  = 1'b0;
    sof_err_d     = sof_err_q;
    s_axis.tready = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = sel_data;
    m_axis.tlast  = sel_last;
    m_axis.tuser  = sel_user;
    beat          = 1'b0;
    premature     = 1'b0;
    cnt_eff       = line_cnt_q;
    drop_sum      = {1'b0, drop_cnt_q} + 17'(stray_n);

    case (state_q)
      IDLE: begin
        s_axis.tready = stray;
        drop_cnt_d    = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
        if (pick_found) begin
          grant_idx_d = pick_idx;
          lines_tgt_d = (cfg_lines == 16'd0) ? 16'd1 : cfg_lines;
          line_cnt_d  = '0;
          first_d     = 1'b1;
          state_d     = LOCK;
        end
      end
      LOCK: begin
        m_axis.tvalid                = sel_valid;
        s_axis.tready[grant_idx_q]   = m_axis.tready[0];
        beat                         = sel_valid & m_axis.tready[0];
        if (beat) begin
          first_d = 1'b0;
          // an SOF mid-frame restarts line counting; the beat itself opens line 0
          if (sel_user && !first_q) begin
            premature  = 1'b1;
            cnt_eff    = '0;
            line_cnt_d = '0;
          end
          if (sel_last) begin
            if (cnt_eff == lines_tgt_q - 16'd1) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
              line_cnt_d   = '0;
              rr_ptr_d     = (grant_idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx_q + 1'b1;
            end else begin
              line_cnt_d = cnt_eff + 16'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    sof_err_d = sof_err_q | premature;
    if (err_clr) begin
      sof_err_d  = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      lines_tgt_q  <= 16'd1;
      line_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      first_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      lines_tgt_q  <= lines_tgt_d;
      line_cnt_q   <= line_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      first_q      <= first_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  assign grant_valid = (state_q == LOCK);
  assign grant_idx   = grant_idx_q;
  assign frame_done  = frame_done_q;
  assign drop_cnt    = drop_cnt_q;
  assign sof_err     = sof_err_q;
endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Shares one AXI-Stream image datapath (passthrough/CNN pipeline input) among NUM_SRC frame sources, such as file readers or camera front-ends.
- Grants a source for one whole frame, from its tuser-marked first beat to the tlast ending its final line, then re-arbitrates round-robin.
- Keeps frames atomic on the shared pipeline.
- Discards stray non-frame-start beats and flags malformed frames.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, data width per beat.
- NUM_SRC, 2, number of slave sources (2..8).
- IDX_W, 1, grant index width; must equal max(1, clog2(NUM_SRC)).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- cfg_lines  in  16  lines per frame; sampled at grant; 0 treated as 1.
- err_clr  in  1  clears sof_err and drop_cnt.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tdata  in  NUM_SRC*C_AXIS_TDATA_WIDTH  per-source data; source i occupies slice i.
- s_axis_tlast  in  NUM_SRC  end of line.
- s_axis_tuser  in  NUM_SRC  start of frame.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tvalid  out  1  to datapath.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH.
- m_axis_tlast  out  1.
- m_axis_tuser  out  1.
- m_axis_tready  in  1  from datapath.
- grant_valid  out  1  a frame is locked.
- grant_idx  out  IDX_W  locked source.
- frame_done  out  1  one-cycle pulse when a frame's final beat completes.
- drop_cnt  out  16  saturating count of discarded beats.
- sof_err  out  1  sticky premature-SOF flag.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset resetn is asynchronous and active-low.
  - On reset: state IDLE, rr_ptr=0, grant_valid=0, grant_idx=0, line_cnt=0, frame_done=0, drop_cnt=0, sof_err=0.
  - While in reset and while IDLE: m_axis_tvalid=0.
  - Reset asserted mid-frame aborts the frame immediately. There is no drain, and the partial frame is not resumed.
- States: IDLE, LOCK.
- IDLE:
  - Candidate = source i with s_axis_tvalid[i]=1 and s_axis_tuser[i]=1.
  - Pick the first candidate searching from rr_ptr upward, modulo NUM_SRC.
  - On a pick, register grant_idx=i, lines_tgt=max(cfg_lines,1) and line_cnt=0, then go to LOCK next cycle.
  - No beat transfers in the arbitration cycle, giving one bubble cycle per frame.
  - Sources with tvalid=1 and tuser=0 are misaligned: drive s_axis_tready[i]=1 to flush them.
    - Each flushed beat increments drop_cnt, saturating at 0xFFFF.
    - Multiple sources flushed in the same cycle add their count.
  - Candidates not picked see tready=0 and hold.
- LOCK:
  - Combinational mux: m_axis_* = s_axis_*[grant_idx], s_axis_tready[grant_idx] = m_axis_tready.
  - All other tready=0; m_axis_tuser is passed through unmodified.
  - A beat is one with m_axis_tvalid and m_axis_tready both high.
  - Beat with tlast=1 and line_cnt = lines_tgt-1 is the final beat:
    - frame_done=1 next cycle, state returns to IDLE.
    - rr_ptr = grant_idx+1, wrapping to 0.
    - grant_valid deasserts next cycle.
  - Beat with tlast=1 otherwise: line_cnt+1.
  - Beat with tuser=1 other than the first beat of the frame (premature SOF):
    - sof_err=1 and line_cnt=0; the frame restarts in place under the same grant.
    - If that same beat also has tlast=1, line_cnt=1.
- Error clearing:
  - err_clr=1 clears sof_err and drop_cnt next cycle.
  - Clear wins over a simultaneous set or increment.
- grant_valid=1 exactly while in LOCK. grant_idx holds its last value in IDLE.
- Arbitration latency: a frame-start beat presented in an IDLE cycle appears on m_axis the following cycle, provided m_axis_tready=1.
- A source deasserting tvalid mid-frame holds the lock; there is no timeout.
- cfg_lines changes during LOCK do not affect the current frame.

Test Plan:
- Single frame: src0 sends 3 lines × 4 beats, tuser on beat 0, cfg_lines=3, m_axis_tready=1.
  - Required: 12 beats out in order, identical data.
  - Required: grant_idx=0, frame_done pulses once after beat 12, grant_valid=0 after it.
- Contention: src0 and src1 both present SOF in the same IDLE cycle, rr_ptr=0.
  - Required: src0 frame first, then src1.
  - Then both request again: src0 wins again (rr_ptr=0 after src1).
  - No interleaving of beats between sources.
- Backpressure: toggle m_axis_tready 1/0 every cycle during a 2-line frame.
  - Required: every beat delivered exactly once.
  - Required: s_axis_tready[sel] mirrors m_axis_tready.
- Misaligned source: src1 presents 5 beats with tuser=0 while IDLE.
  - Required: all 5 flushed, drop_cnt=5, m_axis_tvalid stays 0.
  - Assert err_clr: drop_cnt=0.
- Premature SOF: cfg_lines=4, src0 sends tuser=1 on the first beat of line 2.
  - Required: sof_err=1; frame_done only after 4 further tlast beats.
- Reset mid-frame: deassert resetn during line 1.
  - Required: all outputs at reset values immediately, state IDLE.
  - After release, a new SOF is granted normally; cfg_lines=0 yields frame_done after 1 line.
